// File: rtl/keypad_entry.sv
// keypad_entry: debounces scanner key presses and accumulates decimal digits
// into an 8-bit operand that is handed to the datapath on enter.
module keypad_entry #(
    parameter int DEBOUNCE   = 50000,
    parameter int MAX_DIGITS = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [3:0]                      key_value,
    input  logic                            key_valid,
    input  logic                            clear,
    input  logic                            enter,
    output logic [7:0]                      entry,
    output logic [$clog2(MAX_DIGITS+1)-1:0] digits,
    output logic                            overflow,
    output logic [7:0]                      operand,
    output logic                            operand_valid,
    output logic                            operand_ovf
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [DW-1:0] DIG_MAX  = DW'(MAX_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } key_state_t;

    logic key_s1;
    logic key_s2;
    logic clr_s1;
    logic clr_s2;
    logic clr_d;
    logic clr_p;
    logic ent_s1;
    logic ent_s2;
    logic ent_d;
    logic ent_p;

    key_state_t    state;
    key_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          commit;

    logic [11:0] scaled;
    logic        is_digit;
    logic        room;
    logic        fits;

    // Edge pulses are registered so clear/enter act on the third edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
            clr_s1 <= 1'b0;
            clr_s2 <= 1'b0;
            clr_d  <= 1'b0;
            clr_p  <= 1'b0;
            ent_s1 <= 1'b0;
            ent_s2 <= 1'b0;
            ent_d  <= 1'b0;
            ent_p  <= 1'b0;
        end else begin
            key_s1 <= key_valid;
            key_s2 <= key_s1;
            clr_s1 <= clear;
            clr_s2 <= clr_s1;
            clr_d  <= clr_s2;
            clr_p  <= clr_s2 & ~clr_d;
            ent_s1 <= enter;
            ent_s2 <= ent_s1;
            ent_d  <= ent_s2;
            ent_p  <= ent_s2 & ~ent_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Counter defaults to zero so every state change clears it.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (key_s2) begin
                    state_next = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (!key_s2) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = HELD;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!key_s2) begin
                    state_next = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                if (key_s2) begin
                    state_next = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign scaled   = 12'(entry) * 12'd10 + 12'(key_value);
    assign is_digit = key_value < 4'd10;
    assign room     = digits < DIG_MAX;
    assign fits     = scaled <= 12'd255;

    // Clear beats enter beats commit; a digit racing an enter is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry         <= '0;
            digits        <= '0;
            overflow      <= 1'b0;
            operand       <= '0;
            operand_valid <= 1'b0;
            operand_ovf   <= 1'b0;
        end else begin
            operand_valid <= 1'b0;
            if (clr_p) begin
                entry    <= '0;
                digits   <= '0;
                overflow <= 1'b0;
            end else if (ent_p) begin
                operand       <= entry;
                operand_ovf   <= overflow;
                operand_valid <= 1'b1;
                entry         <= '0;
                digits        <= '0;
                overflow      <= 1'b0;
            end else if (commit && is_digit) begin
                if (room && fits) begin
                    entry  <= scaled[7:0];
                    digits <= digits + 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Digit-accumulation stage directly downstream of the keypad scanner. Takes the scanner's 4-bit key code and key-valid level, debounces and edge-qualifies each press, and assembles successive decimal digits into an 8-bit unsigned operand. On an `enter` press it hands the completed operand to the calculator datapath with a one-cycle strobe. `clear` discards the current entry.

## Interface
- `DEBOUNCE`, default 50000: consecutive `clk` cycles a synchronized key level must hold before a press or release is accepted. Must be ≥ 1.
- `MAX_DIGITS`, default 3: maximum digits per operand, leading zeros included. Must be ≥ 1.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `key_value`  in  4  key code from the scanner; 0–9 are digits, 10–15 are ignored.
- `key_valid`  in  1  scanner key-valid level; asynchronous to `clk`, bouncy.
- `clear`  in  1  clear request level, already debounced, asynchronous.
- `enter`  in  1  enter request level, already debounced, asynchronous.
- `entry`  out  8  live accumulator, for the display.
- `digits`  out  $clog2(MAX_DIGITS+1)  number of digits accepted into `entry`.
- `overflow`  out  1  sticky flag: a digit was rejected during this entry.
- `operand`  out  8  last entered operand; held until the next enter.
- `operand_valid`  out  1  one-cycle strobe; `operand` is new in that cycle.
- `operand_ovf`  out  1  copy of `overflow` captured with `operand`.

## Operation
- **Synchronizers:** `key_valid`, `clear` and `enter` each pass through a 2-flop synchronizer. `clear` and `enter` are then rising-edge detected, giving one-cycle internal pulses.
- **Key FSM states:** IDLE, PRESS_DB, HELD, RELEASE_DB.
- **Key FSM transitions:**
  - IDLE → PRESS_DB when the synchronized valid is 1.
  - In PRESS_DB the counter increments while sync is 1. Sync = 0 returns to IDLE with the counter cleared.
  - When the counter equals DEBOUNCE−1 and sync is still 1, go to HELD and issue the commit.
  - HELD → RELEASE_DB when sync is 0.
  - In RELEASE_DB the counter increments while sync is 0. Sync = 1 returns to HELD with the counter cleared.
  - When the counter equals DEBOUNCE−1 and sync is still 0, go to IDLE.
  - Counter width is $clog2(DEBOUNCE+1). The counter clears on every state change.
- **Commit:** `key_value` is sampled raw on the commit edge; it is stable by then.
  - A code ≥ 10 is ignored: no state change beyond the FSM.
  - A digit d is accepted only if `digits` < MAX_DIGITS and `entry`×10 + d ≤ 255. The sum is computed in 12 bits.
  - If accepted: `entry` ← `entry`×10 + d and `digits` increments.
  - If rejected: `entry` and `digits` are unchanged and `overflow` ← 1.
- **Enter pulse:** `operand` ← `entry`, `operand_ovf` ← `overflow` and `operand_valid` = 1 in the following cycle. Then `entry`, `digits` and `overflow` clear. Enter with zero digits is legal and yields `operand` = 0.
- **Clear pulse:** `entry`, `digits` and `overflow` clear. `operand` is untouched.
- **Same-cycle priority:** clear > enter > commit.
  - A clear suppresses enter; no strobe is issued.
  - An enter coinciding with a commit captures the pre-commit `entry`, and that commit's digit is discarded.
  - The key FSM always advances, regardless of clear or enter.
- **Repeat:** exactly one commit per press. A held key never repeats.

## Timing
- **Reset (`rst_n` low at a `clk` edge):**
  - All outputs are 0: `entry` = 0, `digits` = 0, `overflow` = 0, `operand` = 0, `operand_valid` = 0, `operand_ovf` = 0.
  - The FSM goes to IDLE, and the counters and synchronizers clear.
  - Reset mid-debounce abandons the press. A key still held after reset is debounced afresh and commits once.
- **Key latency:** edge 0 is the first edge that samples `key_valid` = 1, with `key_valid` held high. Sync is high after edge 1, and `entry` updates at edge DEBOUNCE+2.
- **Enter latency:** the `enter` rise is first sampled at edge 0. `operand_valid` is high for exactly the cycle after edge 3. `entry` is 0 after edge 3.
- **Clear latency:** the `clear` rise is first sampled at edge 0, and `entry` is 0 after edge 3.
- **Glitch rejection:** a `key_valid` pulse shorter than DEBOUNCE synchronized cycles produces no commit. A release gap shorter than DEBOUNCE cycles does not end the press.

## Test plan
All scenarios use DEBOUNCE = 4, MAX_DIGITS = 3.
- Press 1, 2, 3 (each 10 cycles high, 10 low), then pulse `enter`. Required: `entry` steps 1 → 12 → 123 and `digits` = 3. `operand` = 123 with `operand_valid` high for 1 cycle and `operand_ovf` = 0. `entry` = 0 afterwards.
- Press 2, 5, 6. Required: after 6, `entry` = 25, `digits` = 2 and `overflow` = 1. Enter gives `operand` = 25 with `operand_ovf` = 1.
- Press 0, 0, 1, 2. Required: `entry` = 1 and `digits` = 3 after the third press. The fourth press sets `overflow` and `entry` stays 1.
- Drive `key_valid` high 3 cycles, low 1, high 3, low 1, then high 8 cycles with key 7. Required: one commit only; `entry` = 7.
- Hold key 9 for 200 cycles. Required: `entry` = 9 and `digits` = 1 throughout. Key code 12 pressed afterwards changes nothing.
- Run two cases:
  - Pulse `clear` and `enter` synchronously with `entry` = 45. Required: `entry` = 0, no strobe, `operand` unchanged.
  - Assert `rst_n` = 0 during PRESS_DB. Required: all outputs 0.
